// File: rtl/net_edge_monitor.sv
// rtl/net_edge_monitor.sv - synchronise, debounce and count qualified rising edges of a resolved net
module net_edge_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TARGET_EDGES  = 1,
  parameter int TIMEOUT       = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              sig,
  output logic                              level,
  output logic                              rise,
  output logic [$clog2(TARGET_EDGES+1)-1:0] edge_count,
  output logic                              busy,
  output logic                              done,
  output logic                              timed_out
);

  localparam int CW = $clog2(TARGET_EDGES + 1);
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TARGET_EDGES - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TMR_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    st_idle,
    st_armed,
    st_done,
    st_timeout
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [SW-1:0]          stab;
  logic [TW-1:0]          timer;
  state_t                 state;

  assign s = sync[SYNC_STAGES-1];

  // The filter runs regardless of FSM state so level is always meaningful.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      stab  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      rise <= 1'b0;
      if (s == level) begin
        stab <= '0;
      end else if (stab == STAB_LAST) begin
        level <= s;
        stab  <= '0;
        rise  <= s;
      end else begin
        stab <= stab + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= st_idle;
      edge_count <= '0;
      timer      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        st_armed: begin
          timer <= timer + TW'(1);
          if (rise) begin
            edge_count <= edge_count + CW'(1);
          end
          // The final edge takes priority over a timer expiring on the same cycle.
          if (rise && edge_count == CNT_LAST) begin
            state <= st_done;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (TMR_EN && timer == TMR_LAST) begin
            state     <= st_timeout;
            busy      <= 1'b0;
            timed_out <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state      <= st_armed;
            edge_count <= '0;
            timer      <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            timed_out  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_net_edge_monitor.sv
// tb/tb_net_edge_monitor.sv - scoreboard bench for net_edge_monitor with a rule-level reference model
module tb_net_edge_monitor;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int TARGET = 3;
  localparam int TMO    = 64;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;
  localparam int M_TO    = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sig   = 1'b0;
  logic       level;
  logic       rise;
  logic [1:0] edge_count;
  logic       busy;
  logic       done;
  logic       timed_out;

  net_edge_monitor #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .TARGET_EDGES (TARGET),
    .TIMEOUT      (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sig       (sig),
    .level     (level),
    .rise      (rise),
    .edge_count(edge_count),
    .busy      (busy),
    .done      (done),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       level;
    logic       rise;
    logic [1:0] cnt;
    logic       busy;
    logic       done;
    logic       to;
  } exp_t;

  exp_t        sbq[$];
  int          checks    = 0;
  int          errors    = 0;
  int unsigned cyc       = 0;
  int          rise_seen = 0;
  int          level_hi  = 0;

  bit          pipe[SYNC];
  bit          m_level;
  bit          m_rise;
  int          m_run;
  int          m_mode;
  int          m_cnt;
  int unsigned m_arm;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: net delayed by the synchroniser depth, level follows after STABLE
  // consecutive disagreeing samples, the monitor measures time since arming.
  task automatic model_step();
    exp_t e;
    bit   s_prev;
    bit   rise_prev;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_run   = 0;
      m_mode  = M_IDLE;
      m_cnt   = 0;
    end else begin
      rise_prev = m_rise;
      s_prev    = pipe[SYNC-1];
      m_rise    = 1'b0;
      if (s_prev != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level = s_prev;
          m_run   = 0;
          m_rise  = s_prev;
        end
      end else begin
        m_run = 0;
      end
      for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = sig;
      if (m_mode == M_ARMED) begin
        if (rise_prev) m_cnt++;
        if (m_cnt == TARGET) m_mode = M_DONE;
        else if (TMO != 0 && cyc - m_arm == TMO) m_mode = M_TO;
      end else if (start) begin
        m_mode = M_ARMED;
        m_cnt  = 0;
        m_arm  = cyc;
      end
    end
    e.level = m_level;
    e.rise  = m_rise;
    e.cnt   = 2'(m_cnt);
    e.busy  = (m_mode == M_ARMED);
    e.done  = (m_mode == M_DONE);
    e.to    = (m_mode == M_TO);
    sbq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_level",      8'(level),      8'(e.level));
        chk("sb_rise",       8'(rise),       8'(e.rise));
        chk("sb_edge_count", 8'(edge_count), 8'(e.cnt));
        chk("sb_busy",       8'(busy),       8'(e.busy));
        chk("sb_done",       8'(done),       8'(e.done));
        chk("sb_timed_out",  8'(timed_out),  8'(e.to));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rise === 1'b1) rise_seen++;
    if (level === 1'b1) level_hi++;
  endtask

  task automatic hold(logic v, int n);
    sig = v;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin : driver
    int          lat;
    int unsigned arm;

    rst_n = 1'b0;
    sig   = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    lat   = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (level === 1'b1 && lat == 0) lat = k;
    end
    chk("reset_release_latency", 8'(lat), 8'd6);

    hold(1'b0, 10);
    rise_seen = 0;
    level_hi  = 0;
    hold(1'b1, 3);
    hold(1'b0, 12);
    chk("glitch_rise_count", 8'(rise_seen), 8'd0);
    chk("glitch_level_high", 8'(level_hi), 8'd0);
    rise_seen = 0;
    hold(1'b1, 5);
    hold(1'b0, 12);
    chk("pulse5_rise_count", 8'(rise_seen), 8'd1);

    pulse_start();
    rise_seen = 0;
    for (int i = 0; i < 8 && done !== 1'b1; i++) hold(~sig, 8);
    sig = 1'b0;
    chk("square_done",       8'(done),       8'd1);
    chk("square_busy",       8'(busy),       8'd0);
    chk("square_edge_count", 8'(edge_count), 8'd3);
    chk("square_rises",      8'(rise_seen),  8'd3);
    hold(1'b0, 4);
    hold(1'b1, 10);
    hold(1'b0, 10);
    chk("post_done_saturate", 8'(edge_count), 8'd3);

    pulse_start();
    arm = cyc;
    for (int k = 0; k < 200 && timed_out !== 1'b1; k++) tick();
    chk("timeout_flag",    8'(timed_out), 8'd1);
    chk("timeout_latency", 8'(cyc - arm), 8'(TMO));
    pulse_start();
    chk("rearm_clears_to", 8'(timed_out), 8'd0);
    chk("rearm_busy",      8'(busy),      8'd1);
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("rearm_done",    8'(done),      8'd1);
    chk("rearm_no_to",   8'(timed_out), 8'd0);

    pulse_start();
    arm = cyc;
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("tie_pre_count", 8'(edge_count), 8'd2);
    while (cyc < arm + 57) tick();
    sig = 1'b1;
    while (cyc < arm + 64) tick();
    chk("tie_done",   8'(done),       8'd1);
    chk("tie_no_to",  8'(timed_out),  8'd0);
    chk("tie_count",  8'(edge_count), 8'd3);
    hold(1'b0, 12);

    pulse_start();
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("midrst_pre_count", 8'(edge_count), 8'd2);
    rst_n = 1'b0;
    tick();
    chk("midrst_outputs", 8'({level, rise, edge_count, busy, done, timed_out}), 8'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 300; i++) begin
      sig = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) begin
        start = ($urandom_range(0, 15) == 0);
        rst_n = ($urandom_range(0, 299) != 0);
        tick();
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    hold(1'b0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_edge_monitor.md
# net_edge_monitor

Sampling stage that sits directly downstream of a strength-resolved single-bit net, such as a `wire (strong1, pull0)` driven from `clk` and exported as `o`. It synchronises and deglitches the resolved net level and counts qualified rising edges. When the programmed number of edges has been seen, it raises a sticky `done` flag; the simulation top level uses this flag as its `$finish` condition. If the edges do not arrive within the timeout window, it raises a sticky `timed_out` flag instead.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth; legal values ≥ 2.
- `STABLE_CYCLES`, 4: consecutive agreeing samples required before the filtered level changes; legal values ≥ 1.
- `TARGET_EDGES`, 1: number of qualified rising edges needed for `done`; legal values ≥ 1.
- `TIMEOUT`, 1024: cycles allowed in ARMED before `timed_out`; 0 disables the timeout.

Ports:
- `clk`, input, 1: sole clock. All state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: single-cycle pulse that arms or re-arms the monitor.
- `sig`, input, 1: the resolved net under observation; asynchronous to `clk`.
- `level`, output, 1: synchronised, debounced value of `sig`.
- `rise`, output, 1: one-cycle pulse on each 0→1 transition of `level`.
- `edge_count`, output, `$clog2(TARGET_EDGES+1)`: number of qualified rising edges since the last arm.
- `busy`, output, 1: high while in ARMED.
- `done`, output, 1: sticky; target edge count reached.
- `timed_out`, output, 1: sticky; timeout expired before the target was reached.

## Operation
- Reset (`rst_n` = 0 at a clock edge): all synchroniser flops, `level`, `rise`, `edge_count`, `busy`, `done` and `timed_out` go to 0. The filter counter and the timer clear. State goes to IDLE.
- Synchroniser: a `SYNC_STAGES`-deep flop chain. Its last stage, `s`, is the only value the rest of the block uses.
- Debounce filter: runs in every state.
  - `stab` counts consecutive cycles with `s != level`. It clears whenever `s == level`.
  - When `s != level` and `stab == STABLE_CYCLES-1`, `level` takes the value of `s` at the next edge and `stab` clears.
  - `rise` is registered and high for exactly the cycle in which `level` has just gone 0→1.
- FSM states: IDLE, ARMED, DONE, TIMEOUT.
  - IDLE: `start` → ARMED. Entering ARMED clears `edge_count` and the timer.
  - ARMED: each `rise` increments `edge_count`. The timer increments every cycle. Transitions:
    - `edge_count` reaches `TARGET_EDGES` → DONE.
    - Otherwise, timer reaches `TIMEOUT-1` (only when `TIMEOUT` ≠ 0) → TIMEOUT.
  - DONE: `done` = 1 and `edge_count` holds. `start` → ARMED, which clears `done`.
  - TIMEOUT: `timed_out` = 1 and `edge_count` holds. `start` → ARMED, which clears `timed_out`.
- Simultaneous events:
  - The final `rise` and timer expiry in the same cycle: DONE wins.
  - `start` while in ARMED: ignored. It does not restart the count.
  - `start` in the same cycle as a `rise` while in IDLE: that `rise` is not counted.
- `edge_count` saturates at `TARGET_EDGES`. Edges arriving in IDLE, DONE or TIMEOUT are not counted.
- `busy` = (state == ARMED). `done` and `timed_out` are never high together.
- Reset mid-operation: the next state is IDLE with every output at its reset value. Any in-progress filter count is discarded.

## Timing
- Latency from `sig` to `level`: `SYNC_STAGES + STABLE_CYCLES` clock edges after the first edge that samples the new value, provided `sig` stays stable throughout. With defaults this is 6 edges.
- Glitch rejection: a pulse on `sig` shorter than `STABLE_CYCLES` cycles at the synchroniser output never changes `level`.
- `rise` coincides with the cycle in which `level` first reads 1.
- Counting: `edge_count` updates one edge after the `rise` cycle. `done` asserts on that same edge.
- Arming: `busy` rises one edge after `start` is sampled.
- Timeout: `timed_out` asserts exactly `TIMEOUT` edges after `busy` rose, if the target has not been met.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- Reset values: hold `rst_n` = 0 for 3 cycles with `sig` = 1 → every output is 0 during reset. After release with `sig` held at 1, `level` reads 1 on the 6th edge.
- Glitch rejection: defaults, `sig` high for 3 cycles then low → `level` stays 0, `rise` never pulses. A following 5-cycle high pulse → `level` = 1 and exactly one `rise`.
- Basic completion: `start`, then one clean 10-cycle high pulse → `edge_count` = 1, `done` = 1, `busy` = 0. A second pulse afterwards leaves `edge_count` at 1.
- Multi-edge count: `TARGET_EDGES` = 3, `sig` toggled every 8 cycles (a square wave similar to a clock-driven net) → `done` asserts after the 3rd `rise`. `edge_count` reads 1, 2, 3 along the way.
- Timeout and re-arm:
  - `TIMEOUT` = 20, `sig` held at 0 → `timed_out` = 1 exactly 20 edges after `busy` rose.
  - Then `start` plus one pulse → `timed_out` clears and `done` = 1.
- Tie and mid-operation reset:
  - Arrange the final `rise` in the same cycle the timer expires → `done` = 1, `timed_out` = 0.
  - Assert `rst_n` = 0 while ARMED with `edge_count` = 2 → the next edge shows IDLE and all outputs 0.
